// File: rtl/wb_regfile_if.sv
// Writeback/decode-side signal bundle of the register file: writeback controls,
// result sources, the two decode read ports and the registered redirect outputs.
interface wb_regfile_if;
  logic        pcload_W;
  logic        regw_W;
  logic        regmem_W;
  logic [3:0]  regScr_W;
  logic [31:0] ALUrslt_W;
  logic [31:0] ReadData_W;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [31:0] pcplus8;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] result_W;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        err_r15;

  modport master (
    output pcload_W, regw_W, regmem_W, regScr_W, ALUrslt_W, ReadData_W,
    output ra1, ra2, pcplus8,
    input  rd1, rd2, result_W, pc_redirect, pc_target, err_r15
  );

  modport slave (
    input  pcload_W, regw_W, regmem_W, regScr_W, ALUrslt_W, ReadData_W,
    input  ra1, ra2, pcplus8,
    output rd1, rd2, result_W, pc_redirect, pc_target, err_r15
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: result select, register commit,
// registered PC redirect, sticky illegal-R15-write flag and two bypassed read ports.
module wb_regfile #(
  parameter int          NREG      = 16,
  parameter int          PC_IDX    = 15,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  localparam logic [3:0] PC_ADDR = 4'(PC_IDX);

  logic [31:0] rf_q [NREG];
  logic [31:0] rf_d [NREG];
  logic        pc_redirect_q, pc_redirect_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic        err_r15_q, err_r15_d;

  logic [31:0] result;
  logic        wr_en;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] rd1, rd2;

  always_comb begin
    result = bus.regmem_W ? bus.ReadData_W : bus.ALUrslt_W;
    wr_en  = bus.regw_W && (bus.regScr_W != PC_ADDR);

    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = (wr_en && (int'(bus.regScr_W) == i)) ? result : rf_q[i];
    end

    pc_redirect_d = bus.pcload_W;
    pc_target_d   = bus.pcload_W ? result : pc_target_q;
    err_r15_d     = err_r15_q ||
                    (bus.regw_W && (bus.regScr_W == PC_ADDR) && !bus.pcload_W);
  end

  // Read mux by comparison loop so an index beyond NREG reads RESET_VAL instead of X.
  always_comb begin
    rf_rd1 = RESET_VAL;
    rf_rd2 = RESET_VAL;
    for (int i = 0; i < NREG; i++) begin
      if (int'(bus.ra1) == i) rf_rd1 = rf_q[i];
      if (int'(bus.ra2) == i) rf_rd2 = rf_q[i];
    end

    if (bus.ra1 == PC_ADDR)                              rd1 = bus.pcplus8;
    else if (bus.regw_W && (bus.ra1 == bus.regScr_W))    rd1 = result;
    else                                                 rd1 = rf_rd1;

    if (bus.ra2 == PC_ADDR)                              rd2 = bus.pcplus8;
    else if (bus.regw_W && (bus.ra2 == bus.regScr_W))    rd2 = result;
    else                                                 rd2 = rf_rd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= RESET_VAL;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= 32'h0;
      err_r15_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
      pc_redirect_q <= pc_redirect_d;
      pc_target_q   <= pc_target_d;
      err_r15_q     <= err_r15_d;
    end
  end

  assign bus.result_W    = result;
  assign bus.rd1         = rd1;
  assign bus.rd2         = rd2;
  assign bus.pc_redirect = pc_redirect_q;
  assign bus.pc_target   = pc_target_q;
  assign bus.err_r15     = err_r15_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by randomized
// traffic checked against an architectural model of the register file and redirect.
module tb_wb_regfile;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  wb_regfile_if bus ();

  wb_regfile #(.NREG(16), .PC_IDX(15), .RESET_VAL(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model state, updated once per rising edge from the sampled inputs.
  logic [31:0] m_rf [16];
  logic        m_redirect;
  logic [31:0] m_target;
  logic        m_err;

  function automatic logic [31:0] m_result();
    return bus.regmem_W ? bus.ReadData_W : bus.ALUrslt_W;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] ra);
    if (ra == 4'd15) return bus.pcplus8;
    if (bus.regw_W && ra == bus.regScr_W) return m_result();
    return m_rf[ra];
  endfunction

  task automatic applyStimulus(input logic pcload, input logic regw, input logic regmem,
                               input logic [3:0] dst, input logic [31:0] alu,
                               input logic [31:0] rdata);
    bus.pcload_W   = pcload;
    bus.regw_W     = regw;
    bus.regmem_W   = regmem;
    bus.regScr_W   = dst;
    bus.ALUrslt_W  = alu;
    bus.ReadData_W = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
      m_redirect = 1'b0;
      m_target   = 32'h0;
      m_err      = 1'b0;
    end else begin
      if (bus.regw_W && bus.regScr_W != 4'd15) m_rf[bus.regScr_W] = m_result();
      if (bus.regw_W && bus.regScr_W == 4'd15 && !bus.pcload_W) m_err = 1'b1;
      m_redirect = bus.pcload_W;
      if (bus.pcload_W) m_target = m_result();
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    bus.ra1 = 4'd0; bus.ra2 = 4'd0; bus.pcplus8 = 32'h1000;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.ra1 = 4'(i);
      #1;
      checks++;
      if (bus.rd1 !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_rd1[%0d]: got %h expected %h", i, bus.rd1, 32'h0);
      end
    end
    checks++;
    if (bus.pc_redirect !== 1'b0 || bus.pc_target !== 32'h0 || bus.err_r15 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got redirect=%b target=%h err=%b expected 0/0/0",
               bus.pc_redirect, bus.pc_target, bus.err_r15);
    end
  endtask

  task automatic test_bypass();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 32'h0000FFFF, 32'h0);
    bus.ra1 = 4'd3;
    #1;
    checks++;
    if (bus.rd1 !== 32'h0000FFFF) begin
      errors++;
      $display("[TB] FAIL bypass_rd1: got %h expected %h", bus.rd1, 32'h0000FFFF);
    end
    tick();
    bus.regw_W = 1'b0;
    #1;
    checks++;
    if (bus.rd1 !== 32'h0000FFFF) begin
      errors++;
      $display("[TB] FAIL stored_rd1: got %h expected %h", bus.rd1, 32'h0000FFFF);
    end
  endtask

  task automatic test_mem_select();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd4, 32'h0000FFFF, 32'hDEADBEEF);
    bus.ra2 = 4'd0;
    #1;
    checks++;
    if (bus.result_W !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL result_mem: got %h expected %h", bus.result_W, 32'hDEADBEEF);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    bus.ra2 = 4'd4;
    #1;
    checks++;
    if (bus.rd2 !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL mem_rd2: got %h expected %h", bus.rd2, 32'hDEADBEEF);
    end
  endtask

  task automatic test_pc_redirect();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h00000040, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    checks++;
    if (bus.pc_redirect !== 1'b1 || bus.pc_target !== 32'h40 || bus.err_r15 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redirect: got redirect=%b target=%h err=%b expected 1/00000040/0",
               bus.pc_redirect, bus.pc_target, bus.err_r15);
    end
    tick();
    checks++;
    if (bus.pc_redirect !== 1'b0 || bus.pc_target !== 32'h40) begin
      errors++;
      $display("[TB] FAIL redirect_drop: got redirect=%b target=%h expected 0/00000040",
               bus.pc_redirect, bus.pc_target);
    end
    bus.ra1 = 4'd15; bus.pcplus8 = 32'h48; bus.ra2 = 4'd3;
    #1;
    checks++;
    if (bus.rd1 !== 32'h48) begin
      errors++;
      $display("[TB] FAIL r15_read: got %h expected %h", bus.rd1, 32'h48);
    end
    checks++;
    if (bus.rd2 !== 32'h0000FFFF) begin
      errors++;
      $display("[TB] FAIL rf_untouched: got %h expected %h", bus.rd2, 32'h0000FFFF);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 32'h00001000, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 32'h0, 32'h00002000);
    checks++;
    if (bus.pc_redirect !== 1'b1 || bus.pc_target !== 32'h1000) begin
      errors++;
      $display("[TB] FAIL b2b_first: got redirect=%b target=%h expected 1/00001000",
               bus.pc_redirect, bus.pc_target);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    checks++;
    if (bus.pc_redirect !== 1'b1 || bus.pc_target !== 32'h2000) begin
      errors++;
      $display("[TB] FAIL b2b_second: got redirect=%b target=%h expected 1/00002000",
               bus.pc_redirect, bus.pc_target);
    end
    tick();
    checks++;
    if (bus.pc_redirect !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drop: got %b expected 0", bus.pc_redirect);
    end
  endtask

  task automatic test_err_r15();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 32'h00000080, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    checks++;
    if (bus.err_r15 !== 1'b1 || bus.pc_redirect !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_set: got err=%b redirect=%b expected 1/0",
               bus.err_r15, bus.pc_redirect);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.err_r15 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %b expected 1", bus.err_r15);
    end
  endtask

  task automatic test_reset_mid_op();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 32'h12345678, 32'h0);
    bus.ra1 = 4'd5;
    #1;
    checks++;
    if (bus.rd1 !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL rst_bypass: got %h expected %h", bus.rd1, 32'h12345678);
    end
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_discard_rf: got %h expected %h", bus.rd1, 32'h0);
    end
    checks++;
    if (bus.pc_redirect !== 1'b0 || bus.pc_target !== 32'h0 || bus.err_r15 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_discard_regs: got redirect=%b target=%h err=%b expected 0/0/0",
               bus.pc_redirect, bus.pc_target, bus.err_r15);
    end
  endtask

  task automatic test_random();
    logic [3:0] dst;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      dst = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), dst, $urandom, $urandom);
      bus.ra1     = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom_range(0, 15));
      bus.ra2     = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom_range(0, 15));
      bus.pcplus8 = $urandom;
      #1;
      checks++;
      if (bus.result_W !== m_result()) begin
        errors++;
        $display("[TB] FAIL rand_result[%0d]: got %h expected %h", n, bus.result_W, m_result());
      end
      checks++;
      if (bus.rd1 !== m_read(bus.ra1) || bus.rd2 !== m_read(bus.ra2)) begin
        errors++;
        $display("[TB] FAIL rand_read[%0d]: got rd1=%h rd2=%h expected %h %h", n,
                 bus.rd1, bus.rd2, m_read(bus.ra1), m_read(bus.ra2));
      end
      tick();
      checks++;
      if (bus.pc_redirect !== m_redirect || bus.pc_target !== m_target ||
          bus.err_r15 !== m_err) begin
        errors++;
        $display("[TB] FAIL rand_regs[%0d]: got %b/%h/%b expected %b/%h/%b", n,
                 bus.pc_redirect, bus.pc_target, bus.err_r15, m_redirect, m_target, m_err);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    $display("[TB] starting wb_regfile bench");
    test_reset();
    test_bypass();
    test_mem_select();
    test_pc_redirect();
    test_back_to_back();
    test_err_r15();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
